huff_freq_count: RTL and testbench
==================================

HUFF_FREQ_COUNT -- requirements
Module: huff_freq_count

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse; clears counts and opens a new frame.
REQ-005 sym_valid  input  1  sym is valid this cycle.
REQ-006 sym  input  3  symbol index; legal values are 0..4.
REQ-007 frame_end  input  1  one-cycle pulse; closes the current frame.
REQ-008 node0..node4  output  13 each  node word {count[7:0], id[4:0]}; bits [12:5] are the weight and bits [4:0] are the symbol id.
REQ-009 sort_begin  output  1  level signal; high while node0..node4 hold a complete, stable frame histogram.
REQ-010 busy  output  1  high while a frame is being counted.
REQ-011 sym_err  output  1  sticky flag; set when sym>4 is presented with sym_valid.

Function
REQ-012 The block SHALL keep five 8-bit counters, cnt0..cnt4, and drive node_i = {cnt_i, 5'd i}.
- The node outputs are continuous functions of the counters.
- The id field SHALL be constant, so node_i[4:0] = i at all times.
REQ-013 The FSM SHALL have exactly three states, with outputs as follows:
- IDLE: busy=0, sort_begin=0.
- COUNT: busy=1, sort_begin=0.
- HOLD: busy=0, sort_begin=1.
REQ-014 In IDLE, start SHALL clear all counters and sym_err and move to COUNT; all other inputs are ignored.
REQ-015 In COUNT, when sym_valid=1 and sym<=4, cnt[sym] SHALL increment by 1 at the next edge.
REQ-016 Counters SHALL saturate at 255; a further increment leaves the counter at 255 and raises no flag.
REQ-017 In COUNT, when sym_valid=1 and sym>4, sym_err SHALL be set to 1 and no counter shall change.
REQ-018 In COUNT, frame_end SHALL move the FSM to HOLD at the next edge.
- A sym_valid in the same cycle as frame_end is counted.
- sort_begin therefore rises exactly 1 cycle after the frame_end cycle, with the final counts already visible.
REQ-019 In COUNT, start SHALL have priority over frame_end and sym_valid.
- All counters and sym_err clear.
- The FSM stays in COUNT.
- The symbol presented in that cycle is discarded.
REQ-020 In HOLD, the counters SHALL remain frozen, and sym_valid and frame_end SHALL be ignored, so node0..node4 are stable for the whole time sort_begin=1.
REQ-021 In HOLD, start SHALL clear all counters and sym_err and move to COUNT, so sort_begin falls at the same edge.
REQ-022 Downstream sorters SHALL treat sort_begin as a level that stays high until the next start; the block does not wait for sort completion.
REQ-023 Symbols with zero occurrences SHALL still be emitted, with weight 0.
REQ-024 Each sym_err assertion SHALL be held until the next start or reset.
REQ-025 The total symbol count is not tracked; frames longer than 255 of one symbol rely on saturation (REQ-016).

Reset
REQ-026 On nRST=0, the block SHALL immediately set the following:
- FSM to IDLE;
- cnt0..cnt4 to 0, so node_i = {8'd0, 5'd i};
- sort_begin=0, busy=0, sym_err=0.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard all counts; the block resumes only on a new start after nRST returns high.

Verification
REQ-028 Basic frame. Stimulus: start; sym sequence 0,1,1,4,4,4,2; frame_end in the cycle after the last symbol. Required response:
- sort_begin rises 1 cycle after frame_end;
- node0=13'h0020, node1=13'h0041, node2=13'h0022, node3=13'h0003, node4=13'h0064.
REQ-029 Saturation. Stimulus: 300 sym_valid cycles with sym=3, then frame_end. Required response: node3[12:5]=255, all other weights 0.
REQ-030 Illegal symbol. Stimulus: within a frame, sym=5 and sym=7 with sym_valid. Required response: sym_err=1 from the next edge, counts unchanged, sym_err still 1 in HOLD, cleared by the next start.
REQ-031 Simultaneous events. Stimulus: (a) sym_valid sym=2 together with frame_end; (b) start together with sym_valid sym=0 and frame_end while in COUNT. Required response:
- (a) node2 weight includes that symbol.
- (b) all weights 0, FSM stays in COUNT, sort_begin stays 0.
REQ-032 HOLD behaviour. Stimulus: in HOLD, apply sym_valid and frame_end for 10 cycles, then start. Required response: nodes unchanged and sort_begin=1 throughout; after start, sort_begin=0, busy=1 and all weights 0 at the next edge.
REQ-033 Reset mid-frame. Stimulus: after 5 symbols, pulse nRST low asynchronously. Required response: outputs return to reset values at once; sym_valid with no start leaves counts at 0 and keeps busy=0.

Source files
------------

// File: rtl/huff_freq_count.sv
// huff_freq_count: five-bin symbol histogram for a Huffman tree builder.
// Counts symbols 0..4 over a frame delimited by start/frame_end, then holds
// the histogram as node words {weight[7:0], id[4:0]} for a downstream sorter.
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   start                pulse: clear counts and sym_err, open a new frame
//   sym_valid, sym[2:0]  symbol strobe and index (legal 0..4)
//   frame_end            pulse: close the current frame
//   node0..node4         node words {cnt_i, 5'd i}
//   sort_begin           high while node0..node4 hold a stable histogram
//   busy                 high while a frame is being counted
//   sym_err              sticky flag for an illegal symbol index
module huff_freq_count (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        sym_valid,
  input  logic [2:0]  sym,
  input  logic        frame_end,
  output logic [12:0] node0,
  output logic [12:0] node1,
  output logic [12:0] node2,
  output logic [12:0] node3,
  output logic [12:0] node4,
  output logic        sort_begin,
  output logic        busy,
  output logic        sym_err
);

  localparam int unsigned NUM_SYM = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ID_W    = 5;
  localparam int unsigned SYM_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt [NUM_SYM];
  logic             clear, cnt_en, err_set;
  logic             busy_d, sort_begin_d;
  logic             sym_legal;

  assign sym_legal = (sym < SYM_W'(NUM_SYM));

  // State register plus registered versions of the state-decoded outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sort_begin <= 1'b0;
    end else begin
      state      <= state_d;
      busy       <= busy_d;
      sort_begin <= sort_begin_d;
    end
  end

  // Next-state and datapath control; start wins over everything in any state
  always_comb begin
    state_d      = state;
    clear        = 1'b0;
    cnt_en       = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (start) begin
          clear = 1'b1;
        end else begin
          if (sym_valid) begin
            if (sym_legal) cnt_en  = 1'b1;
            else           err_set = 1'b1;
          end
          if (frame_end) state_d = HOLD;
        end
      end
      HOLD: begin
        if (start) begin
          clear   = 1'b1;
          state_d = COUNT;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs follow the state being entered so they line up with it
    busy_d       = (state_d == COUNT);
    sort_begin_d = (state_d == HOLD);
  end

  // Saturating per-symbol counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_SYM; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_SYM; i++) cnt[i] <= '0;
    end else if (cnt_en) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        if ((sym == SYM_W'(i)) && (cnt[i] != {CNT_W{1'b1}}))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Sticky illegal-symbol flag, cleared only by start or reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        sym_err <= 1'b0;
    else if (clear)   sym_err <= 1'b0;
    else if (err_set) sym_err <= 1'b1;
  end

  assign node0 = {cnt[0], ID_W'(0)};
  assign node1 = {cnt[1], ID_W'(1)};
  assign node2 = {cnt[2], ID_W'(2)};
  assign node3 = {cnt[3], ID_W'(3)};
  assign node4 = {cnt[4], ID_W'(4)};

endmodule

// File: tb/tb_huff_freq_count.sv
// Directed testbench for huff_freq_count: one task per scenario, inline checks.
module tb_huff_freq_count;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic        sym_valid;
  logic [2:0]  sym;
  logic        frame_end;
  logic [12:0] node0, node1, node2, node3, node4;
  logic        sort_begin, busy, sym_err;
  logic [12:0] nd [5];

  int errors = 0;
  int checks = 0;

  huff_freq_count dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .start      (start),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .frame_end  (frame_end),
    .node0      (node0),
    .node1      (node1),
    .node2      (node2),
    .node3      (node3),
    .node4      (node4),
    .sort_begin (sort_begin),
    .busy       (busy),
    .sym_err    (sym_err)
  );

  assign nd[0] = node0;
  assign nd[1] = node1;
  assign nd[2] = node2;
  assign nd[3] = node3;
  assign nd[4] = node4;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; sym_valid = 1'b0; sym = 3'd0; frame_end = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_sym(input logic [2:0] s);
    sym_valid = 1'b1; sym = s; tick(); sym_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] exp_n [5];
    for (int i = 0; i < 5; i++) exp_n[i] = 13'(i);
    idle_inputs();
    nRST = 1'b0;
    #3;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (nd[i] !== exp_n[i]) begin
        errors++;
        $display("FAIL reset_node%0d: got %h want %h", i, nd[i], exp_n[i]);
      end
    end
    checks++;
    if ({sort_begin, busy, sym_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got sb/busy/err=%b want 000", {sort_begin, busy, sym_err});
    end
    tick();
    nRST = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [12:0] exp_n [5];
    logic [2:0]  seq [7];
    exp_n[0] = 13'h0020; exp_n[1] = 13'h0041; exp_n[2] = 13'h0022;
    exp_n[3] = 13'h0003; exp_n[4] = 13'h0064;
    seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd1; seq[3] = 3'd4;
    seq[4] = 3'd4; seq[5] = 3'd4; seq[6] = 3'd2;
    pulse_start();
    checks++;
    if ({busy, sort_begin} !== 2'b10) begin
      errors++;
      $display("FAIL basic_count_state: got busy/sb=%b want 10", {busy, sort_begin});
    end
    for (int i = 0; i < 7; i++) send_sym(seq[i]);
    frame_end = 1'b1;
    checks++;
    if (sort_begin !== 1'b0) begin
      errors++;
      $display("FAIL basic_sb_early: got %b want 0", sort_begin);
    end
    tick();
    frame_end = 1'b0;
    checks++;
    if ({busy, sort_begin} !== 2'b01) begin
      errors++;
      $display("FAIL basic_hold_state: got busy/sb=%b want 01", {busy, sort_begin});
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (nd[i] !== exp_n[i]) begin
        errors++;
        $display("FAIL basic_node%0d: got %h want %h", i, nd[i], exp_n[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_w [5];
    exp_w[0] = 8'd0; exp_w[1] = 8'd0; exp_w[2] = 8'd0; exp_w[3] = 8'd255; exp_w[4] = 8'd0;
    pulse_start();
    sym_valid = 1'b1; sym = 3'd3;
    for (int i = 0; i < 300; i++) tick();
    sym_valid = 1'b0;
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (nd[i][12:5] !== exp_w[i] || nd[i][4:0] !== 5'(i)) begin
        errors++;
        $display("FAIL sat_node%0d: got w=%0d id=%0d want w=%0d id=%0d",
                 i, nd[i][12:5], nd[i][4:0], exp_w[i], i);
      end
    end
    checks++;
    if (sym_err !== 1'b0) begin
      errors++;
      $display("FAIL sat_no_err: got %b want 0", sym_err);
    end
  endtask

  task automatic test_illegal();
    pulse_start();
    send_sym(3'd0);
    send_sym(3'd5);
    checks++;
    if (sym_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err_set: got %b want 1", sym_err);
    end
    send_sym(3'd7);
    checks++;
    if ({node0, node1, node2, node3, node4} !== {13'h0020, 13'h0001, 13'h0002, 13'h0003, 13'h0004}) begin
      errors++;
      $display("FAIL illegal_counts: got %h %h %h %h %h want 0020 0001 0002 0003 0004",
               node0, node1, node2, node3, node4);
    end
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    checks++;
    if ({sort_begin, sym_err} !== 2'b11) begin
      errors++;
      $display("FAIL illegal_hold_err: got sb/err=%b want 11", {sort_begin, sym_err});
    end
    pulse_start();
    checks++;
    if ({busy, sym_err} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_err_clear: got busy/err=%b want 10", {busy, sym_err});
    end
  endtask

  // Entered in COUNT with cleared counters (left there by test_illegal)
  task automatic test_simultaneous();
    send_sym(3'd2);
    sym_valid = 1'b1; sym = 3'd2; frame_end = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (node2 !== 13'h0042 || sort_begin !== 1'b1) begin
      errors++;
      $display("FAIL simul_a: got node2=%h sb=%b want 0042 1", node2, sort_begin);
    end
    pulse_start();
    send_sym(3'd1);
    start = 1'b1; sym_valid = 1'b1; sym = 3'd0; frame_end = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({node0, node1, node2, node3, node4} !== {13'h0000, 13'h0001, 13'h0002, 13'h0003, 13'h0004}) begin
      errors++;
      $display("FAIL simul_b_counts: got %h %h %h %h %h want 0000 0001 0002 0003 0004",
               node0, node1, node2, node3, node4);
    end
    checks++;
    if ({busy, sort_begin} !== 2'b10) begin
      errors++;
      $display("FAIL simul_b_state: got busy/sb=%b want 10", {busy, sort_begin});
    end
  endtask

  // Entered in COUNT with cleared counters
  task automatic test_hold();
    int bad = 0;
    send_sym(3'd4);
    send_sym(3'd4);
    send_sym(3'd0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    sym_valid = 1'b1; frame_end = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sym = 3'(i % 5);
      tick();
      checks++;
      if (node4 !== 13'h0044 || node0 !== 13'h0020 || node1 !== 13'h0001 ||
          sort_begin !== 1'b1 || busy !== 1'b0) begin
        errors++;
        bad++;
        $display("FAIL hold_cycle%0d: got n0=%h n1=%h n4=%h sb=%b busy=%b want 0020 0001 0044 1 0",
                 i, node0, node1, node4, sort_begin, busy);
      end
    end
    idle_inputs();
    pulse_start();
    checks++;
    if ({sort_begin, busy} !== 2'b01 || node4 !== 13'h0004 || node0 !== 13'h0000) begin
      errors++;
      $display("FAIL hold_restart: got sb/busy=%b n0=%h n4=%h want 01 0000 0004",
               {sort_begin, busy}, node0, node4);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_sym(3'd1); send_sym(3'd2); send_sym(3'd3); send_sym(3'd3); send_sym(3'd5);
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if ({node0, node1, node2, node3, node4} !== {13'h0000, 13'h0001, 13'h0002, 13'h0003, 13'h0004} ||
        {sort_begin, busy, sym_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_async: got %h %h %h %h %h flags=%b want 0000 0001 0002 0003 0004 000",
               node0, node1, node2, node3, node4, {sort_begin, busy, sym_err});
    end
    #1;
    nRST = 1'b1;
    send_sym(3'd2); send_sym(3'd2); send_sym(3'd0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    checks++;
    if (node2 !== 13'h0002 || node0 !== 13'h0000 || {busy, sort_begin} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_ignore: got n0=%h n2=%h busy/sb=%b want 0000 0002 00",
               node0, node2, {busy, sort_begin});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_illegal();
    test_simultaneous();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
